// File: rtl/dot_seq_nxn_pkg.sv
// dot_pkg: shared types and elaboration-time helpers for dot_seq_nxn.
//
// Contents:
//   dot_state_t        IDLE / RUN / DONE encoding of the engine FSM.
//   dot_steps()        number of RUN cycles (ARRAY_SIZE / LANES).
//   dot_cnt_bits()     step counter width, never less than 1 bit.
//   dot_sat_max/min()  signed limits of a w-bit two's complement value,
//                      returned at DOT_LIM_W bits so callers can size-cast.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dot_state_t;

  localparam int DOT_LIM_W = 128;

  function automatic int dot_steps(input int array_size, input int lanes);
    return array_size / lanes;
  endfunction

  function automatic int dot_cnt_bits(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic logic signed [DOT_LIM_W-1:0] dot_sat_max(input int w);
    return (DOT_LIM_W'(1) <<< (w - 1)) - DOT_LIM_W'(1);
  endfunction

  function automatic logic signed [DOT_LIM_W-1:0] dot_sat_min(input int w);
    return ~dot_sat_max(w);
  endfunction

endpackage

// File: rtl/dot_seq_nxn_if.sv
// dot_seq_nxn_if: operand/result bundle of the dot_seq_nxn engine.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both
//   high. The producer holds valid and its payload stable until that edge;
//   valid never depends combinationally on ready. On the input channel
//   in_ready is high only while the engine is idle, and in_valid is ignored
//   otherwise. On the output channel out_valid, z and sat stay stable until
//   out_ready is seen; out_ready is ignored while out_valid is low.
//
// Signals:
//   in_valid/in_ready   operand pair handshake
//   a_vec/b_vec         ARRAY_SIZE packed signed elements, element i at
//                       [i*A_BITS +: A_BITS]
//   out_valid/out_ready result handshake
//   z                   signed dot product, Z_BITS wide
//   sat                 saturation flag for the presented result
//   busy                engine is running or holding a result
//
// Modports: slave = engine side, master = producer/consumer side.
interface dot_seq_nxn_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int A_BITS     = 12,
  parameter int Z_BITS     = 28
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ARRAY_SIZE*A_BITS-1:0] a_vec;
  logic [ARRAY_SIZE*A_BITS-1:0] b_vec;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [Z_BITS-1:0]     z;
  logic                         sat;
  logic                         busy;

  modport slave (
    input  in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, z, sat, busy
  );

  modport master (
    output in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, z, sat, busy
  );
endinterface

// File: rtl/dot_seq_nxn_lane_sum.sv
// dot_lane_sum: combinational LANES-way signed multiply and sum.
//
// Ports:
//   a_slice, b_slice  LANES packed signed elements, lane l at
//                     [l*A_BITS +: A_BITS]
//   lane_sum          sum of the LANES products, each product
//                     (2*A_BITS signed) sign-extended to S_BITS first
//
// S_BITS must be at least 2*A_BITS; when the caller needs the lane sum to
// be exact it adds $clog2(LANES) bits of headroom.
module dot_lane_sum #(
  parameter int LANES  = 1,
  parameter int A_BITS = 12,
  parameter int S_BITS = 28
) (
  input  logic [LANES*A_BITS-1:0] a_slice,
  input  logic [LANES*A_BITS-1:0] b_slice,
  output logic signed [S_BITS-1:0] lane_sum
);

  localparam int P_BITS = 2 * A_BITS;

  logic signed [P_BITS-1:0] prod [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [A_BITS-1:0] a_e;
    logic signed [A_BITS-1:0] b_e;
    assign a_e = a_slice[l*A_BITS +: A_BITS];
    assign b_e = b_slice[l*A_BITS +: A_BITS];
    // Widen before multiplying so the product is computed at full width.
    assign prod[l] = P_BITS'(a_e) * P_BITS'(b_e);
  end

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + S_BITS'(prod[l]);
    end
  end

endmodule

// File: rtl/dot_seq_nxn.sv
// dot_seq_nxn: sequenced signed dot-product engine.
//
// Accepts a pair of ARRAY_SIZE-element vectors, walks them LANES elements
// per cycle for STEPS = ARRAY_SIZE/LANES cycles, accumulates the products
// and presents the sum on a held valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (aborts any operation)
//   bus        dot_seq_nxn_if.slave: in_valid/in_ready/a_vec/b_vec,
//              out_valid/out_ready/z/sat/busy
//   state_dbg  current FSM state (dot_state_t encoding)
//
// Build option:
//   DOT_SAT_EN  when defined, each accumulation is computed with extra
//               headroom and clamped to the Z_BITS signed range; a sticky
//               sat flag records any clamp. When undefined the accumulator
//               wraps modulo 2^Z_BITS and sat is tied to 0.
module dot_seq_nxn
  import dot_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int LANES      = 1,
  parameter int A_BITS     = 12,
  parameter int Z_BITS     = 28
) (
  input  logic                clk,
  input  logic                rst,
  dot_seq_nxn_if.slave        bus,
  output logic [1:0]          state_dbg
);

  localparam int STEPS  = dot_steps(ARRAY_SIZE, LANES);
  localparam int CNT_W  = dot_cnt_bits(STEPS);
  localparam int CHUNKS = 2 ** CNT_W;
  localparam int SLICE  = LANES * A_BITS;

`ifdef DOT_SAT_EN
  localparam int LANE_W = $clog2(LANES);
  localparam int SUM_W  = Z_BITS + LANE_W;
  localparam int ACC_W  = Z_BITS + LANE_W + 1;
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(dot_sat_max(Z_BITS));
  localparam logic signed [ACC_W-1:0] Z_MIN = ACC_W'(dot_sat_min(Z_BITS));
`else
  localparam int SUM_W  = Z_BITS;
  localparam int ACC_W  = Z_BITS;
`endif

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]                   state;
  logic [CNT_W-1:0]             step;
  logic [ARRAY_SIZE*A_BITS-1:0] a_reg;
  logic [ARRAY_SIZE*A_BITS-1:0] b_reg;
  logic signed [Z_BITS-1:0]     acc;
  logic signed [Z_BITS-1:0]     acc_next;
  logic signed [Z_BITS-1:0]     z_reg;
  logic                         out_valid_r;

  logic [SLICE-1:0]             a_slice;
  logic [SLICE-1:0]             b_slice;
  logic signed [SUM_W-1:0]      lane_sum;
  logic signed [ACC_W-1:0]      acc_wide;

  // Slice table padded to a power of two so the step counter indexes it
  // with exactly its own width; padding entries are never selected.
  logic [SLICE-1:0] a_chunks [CHUNKS];
  logic [SLICE-1:0] b_chunks [CHUNKS];

  for (genvar s = 0; s < CHUNKS; s++) begin : g_chunk
    if (s < STEPS) begin : g_used
      assign a_chunks[s] = a_reg[s*SLICE +: SLICE];
      assign b_chunks[s] = b_reg[s*SLICE +: SLICE];
    end else begin : g_pad
      assign a_chunks[s] = '0;
      assign b_chunks[s] = '0;
    end
  end

  assign a_slice = a_chunks[step];
  assign b_slice = b_chunks[step];

  dot_lane_sum #(
    .LANES  (LANES),
    .A_BITS (A_BITS),
    .S_BITS (SUM_W)
  ) u_lane_sum (
    .a_slice  (a_slice),
    .b_slice  (b_slice),
    .lane_sum (lane_sum)
  );

  assign acc_wide = ACC_W'(acc) + ACC_W'(lane_sum);

`ifdef DOT_SAT_EN
  logic clamp;
  logic sat_r;

  always_comb begin
    acc_next = Z_BITS'(acc_wide);
    clamp    = 1'b0;
    if (acc_wide > Z_MAX) begin
      acc_next = Z_BITS'(Z_MAX);
      clamp    = 1'b1;
    end else if (acc_wide < Z_MIN) begin
      acc_next = Z_BITS'(Z_MIN);
      clamp    = 1'b1;
    end
  end

  assign bus.sat = sat_r;
`else
  assign acc_next = acc_wide;
  assign bus.sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      step        <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      z_reg       <= '0;
      out_valid_r <= 1'b0;
`ifdef DOT_SAT_EN
      sat_r       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a_vec;
            b_reg <= bus.b_vec;
            acc   <= '0;
            step  <= '0;
`ifdef DOT_SAT_EN
            sat_r <= 1'b0;
`endif
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
`ifdef DOT_SAT_EN
          sat_r <= sat_r | clamp;
`endif
          if (step == LAST_STEP) begin
            // Counter parks at 0 so it never indexes a padding slice.
            step        <= '0;
            z_reg       <= acc_next;
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end else begin
            step <= step + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
  assign bus.out_valid = out_valid_r;
  assign bus.z         = z_reg;
  assign state_dbg     = state;

endmodule

// File: tb/tb_dot_seq_nxn.sv
// Bench for dot_seq_nxn: three instances (LANES=1/Z=28, LANES=2/Z=28,
// LANES=4/Z=24) share one clock, reset and operand drivers; sel chooses
// which instance sees in_valid and which outputs are observed.
module tb_dot_seq_nxn;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- drivers ----------------
  int          sel;
  logic        in_valid_drv;
  logic        out_ready_drv;
  logic [47:0] a_drv;
  logic [47:0] b_drv;

  dot_seq_nxn_if #(.ARRAY_SIZE(4), .A_BITS(12), .Z_BITS(28)) if1 ();
  dot_seq_nxn_if #(.ARRAY_SIZE(4), .A_BITS(12), .Z_BITS(28)) if2 ();
  dot_seq_nxn_if #(.ARRAY_SIZE(4), .A_BITS(12), .Z_BITS(24)) if3 ();

  logic [1:0] st1, st2, st3;

  assign if1.in_valid  = in_valid_drv && (sel == 1);
  assign if2.in_valid  = in_valid_drv && (sel == 2);
  assign if3.in_valid  = in_valid_drv && (sel == 3);
  assign if1.a_vec     = a_drv;
  assign if2.a_vec     = a_drv;
  assign if3.a_vec     = a_drv;
  assign if1.b_vec     = b_drv;
  assign if2.b_vec     = b_drv;
  assign if3.b_vec     = b_drv;
  assign if1.out_ready = out_ready_drv;
  assign if2.out_ready = out_ready_drv;
  assign if3.out_ready = out_ready_drv;

  dot_seq_nxn #(.ARRAY_SIZE(4), .LANES(1), .A_BITS(12), .Z_BITS(28)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .state_dbg(st1));
  dot_seq_nxn #(.ARRAY_SIZE(4), .LANES(2), .A_BITS(12), .Z_BITS(28)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .state_dbg(st2));
  dot_seq_nxn #(.ARRAY_SIZE(4), .LANES(4), .A_BITS(12), .Z_BITS(24)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .state_dbg(st3));

  // Observed outputs of the selected instance.
  logic                    cur_in_ready, cur_out_valid, cur_sat, cur_busy;
  logic signed [27:0]      cur_z;
  logic [1:0]              cur_st;

  always_comb begin
    cur_in_ready  = if1.in_ready;
    cur_out_valid = if1.out_valid;
    cur_sat       = if1.sat;
    cur_busy      = if1.busy;
    cur_z         = if1.z;
    cur_st        = st1;
    case (sel)
      2: begin
        cur_in_ready  = if2.in_ready;
        cur_out_valid = if2.out_valid;
        cur_sat       = if2.sat;
        cur_busy      = if2.busy;
        cur_z         = if2.z;
        cur_st        = st2;
      end
      3: begin
        cur_in_ready  = if3.in_ready;
        cur_out_valid = if3.out_valid;
        cur_sat       = if3.sat;
        cur_busy      = if3.busy;
        cur_z         = 28'(if3.z);
        cur_st        = st3;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {12'(e3), 12'(e2), 12'(e1), 12'(e0)};
  endfunction

  task automatic accept(input string name);
    int n = 0;
    while (!cur_in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready"}, longint'(cur_in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!cur_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_out_valid"}, longint'(cur_out_valid), 1);
  endtask

  task automatic run_op(input string name, input int which, input logic [47:0] a,
                        input logic [47:0] b, output longint z, output logic s,
                        output int lat);
    sel          = which;
    a_drv        = a;
    b_drv        = b;
    in_valid_drv = 1'b1;
    accept(name);
    in_valid_drv = 1'b0;
    wait_out(name, lat);
    z = longint'(cur_z);
    s = cur_sat;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          which;
    logic [47:0] a;
    logic [47:0] b;
    longint      exp_z;
    logic        exp_sat;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input int which, input logic [47:0] a, input logic [47:0] b,
                              input longint z, input logic s, input int lat);
    vec_t v;
    v.which   = which;
    v.a       = a;
    v.b       = b;
    v.exp_z   = z;
    v.exp_sat = s;
    v.exp_lat = lat;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] pa, pb, pc, pd, pe_a, pe_b, pf_a, pf_b, pg_a, pg_b, pb_a, pb_b;
    longint      z;
    logic        s;
    int          lat;
    int          out_cyc [3];
    logic [47:0] bb_a [3];
    logic [47:0] bb_b [3];
    longint      bb_z [3];

    rst           = 1'b0;
    sel           = 1;
    in_valid_drv  = 1'b0;
    out_ready_drv = 1'b1;
    a_drv         = '0;
    b_drv         = '0;

    pa   = pack4(1, 2, 3, 4);          pb   = pack4(5, 6, 7, 8);           // 70
    pb_a = pack4(-3, 2, -1, 4);        pb_b = pack4(5, -6, 7, 8);          // -2
    pc   = pack4(-2048, -2048, -2048, -2048);                             // 2^24
    pd   = pack4(1, 1, 1, 1);                                             // 4
    pe_a = pack4(2047, -2048, 100, -7); pe_b = pack4(2047, 2047, -50, 3); // -7068
    pf_a = pack4(0, 0, 0, 0);          pf_b = pack4(123, -456, 789, -1000); // 0
    pg_a = pack4(10, -20, 30, -40);    pg_b = pack4(-1, -1, -1, -1);       // 20

    vecs[0]  = mk(1, pa,   pb,   70,       1'b0, 4);
    vecs[1]  = mk(2, pa,   pb,   70,       1'b0, 2);
    vecs[2]  = mk(2, pb_a, pb_b, -2,       1'b0, 2);
    vecs[3]  = mk(1, pb_a, pb_b, -2,       1'b0, 4);
    vecs[4]  = mk(1, pe_a, pe_b, -7068,    1'b0, 4);
    vecs[5]  = mk(2, pg_a, pg_b, 20,       1'b0, 2);
    vecs[6]  = mk(3, pa,   pb,   70,       1'b0, 1);
`ifdef DOT_SAT_EN
    vecs[7]  = mk(3, pc,   pc,   8388607,  1'b1, 1);
`else
    vecs[7]  = mk(3, pc,   pc,   0,        1'b0, 1);
`endif
    vecs[8]  = mk(3, pd,   pd,   4,        1'b0, 1);
    vecs[9]  = mk(1, pc,   pc,   16777216, 1'b0, 4);
    vecs[10] = mk(2, pf_a, pf_b, 0,        1'b0, 2);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) begin
      sel = i;
      #1;
      check($sformatf("rst%0d_out_valid", i), longint'(cur_out_valid), 0);
      check($sformatf("rst%0d_z", i), longint'(cur_z), 0);
      check($sformatf("rst%0d_sat", i), longint'(cur_sat), 0);
      check($sformatf("rst%0d_busy", i), longint'(cur_busy), 0);
      check($sformatf("rst%0d_state", i), longint'(cur_st), 0);
    end
    rst = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      sel = i;
      #1;
      check($sformatf("rel%0d_in_ready", i), longint'(cur_in_ready), 1);
    end
    @(posedge clk); #1;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].which, vecs[i].a, vecs[i].b, z, s, lat);
      check($sformatf("vec%0d_z", i), z, vecs[i].exp_z);
      check($sformatf("vec%0d_sat", i), longint'(s), longint'(vecs[i].exp_sat));
      check($sformatf("vec%0d_lat", i), longint'(lat), longint'(vecs[i].exp_lat));
    end

    // ---- result held while out_ready is low; in_valid ignored ----
    sel           = 1;
    out_ready_drv = 1'b0;
    a_drv         = pa;
    b_drv         = pb;
    in_valid_drv  = 1'b1;
    accept("hold");
    a_drv = pb_a;
    b_drv = pb_b;
    wait_out("hold", lat);
    check("hold_lat", longint'(lat), 4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_out_valid", k), longint'(cur_out_valid), 1);
      check($sformatf("hold%0d_z", k), longint'(cur_z), 70);
      check($sformatf("hold%0d_sat", k), longint'(cur_sat), 0);
      check($sformatf("hold%0d_in_ready", k), longint'(cur_in_ready), 0);
      check($sformatf("hold%0d_state", k), longint'(cur_st), 2);
      @(posedge clk); #1;
    end
    out_ready_drv = 1'b1;
    @(posedge clk); #1;
    check("hold_release_state", longint'(cur_st), 0);
    check("hold_release_out_valid", longint'(cur_out_valid), 0);
    @(posedge clk); #1;
    check("hold_next_state", longint'(cur_st), 1);
    in_valid_drv = 1'b0;
    wait_out("hold_next", lat);
    check("hold_next_lat", longint'(lat), 4);
    check("hold_next_z", longint'(cur_z), -2);
    @(posedge clk); #1;

    // ---- reset in the middle of RUN ----
    sel          = 1;
    a_drv        = pe_a;
    b_drv        = pe_b;
    in_valid_drv = 1'b1;
    accept("abort");
    in_valid_drv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_state_run", longint'(cur_st), 1);
    rst = 1'b0;
    #1;
    check("abort_out_valid", longint'(cur_out_valid), 0);
    check("abort_z", longint'(cur_z), 0);
    check("abort_busy", longint'(cur_busy), 0);
    check("abort_state", longint'(cur_st), 0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", longint'(cur_in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_output", longint'(cur_out_valid), 0);
    run_op("fresh", 1, pg_a, pg_b, z, s, lat);
    check("fresh_z", z, 20);
    check("fresh_sat", longint'(s), 0);
    check("fresh_lat", longint'(lat), 4);

    // ---- back-to-back with in_valid held high ----
    bb_a[0] = pa;   bb_b[0] = pb;   bb_z[0] = 70;
    bb_a[1] = pe_a; bb_b[1] = pe_b; bb_z[1] = -7068;
    bb_a[2] = pg_a; bb_b[2] = pg_b; bb_z[2] = 20;
    sel           = 1;
    out_ready_drv = 1'b1;
    in_valid_drv  = 1'b1;
    for (int p = 0; p < 3; p++) begin
      a_drv = bb_a[p];
      b_drv = bb_b[p];
      accept($sformatf("b2b%0d", p));
      wait_out($sformatf("b2b%0d", p), lat);
      out_cyc[p] = cyc;
      check($sformatf("b2b%0d_z", p), longint'(cur_z), bb_z[p]);
      check($sformatf("b2b%0d_lat", p), longint'(lat), 4);
    end
    in_valid_drv = 1'b0;
    check("b2b_gap01", longint'(out_cyc[1] - out_cyc[0]), 6);
    check("b2b_gap12", longint'(out_cyc[2] - out_cyc[1]), 6);
    @(posedge clk); #1;
    check("b2b_end_out_valid", longint'(cur_out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_seq_nxn.md
Name: dot_seq_nxn

Overview:
Sequenced, parametrised dot-product engine that accepts two ARRAY_SIZE-element signed vectors through a valid/ready handshake. It walks the elements internally, LANES products per cycle, and accumulates the sum. It returns the sum through a held valid/ready output. It supersedes externally-selected single-MAC dot blocks: element selection, step counting and accumulator clearing are all internal.

Parameters:
ARRAY_SIZE, 4, elements per vector; must be a multiple of LANES.
LANES, 1, products summed per cycle; 1 <= LANES <= ARRAY_SIZE.
A_BITS, 12, signed element width.
Z_BITS, 28, signed accumulator/result width; must be >= 2*A_BITS.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  vector pair offered.
in_ready  out  1  engine can accept a pair; high only in IDLE.
a_vec  in  ARRAY_SIZE*A_BITS  element i at bits [i*A_BITS +: A_BITS], two's complement.
b_vec  in  ARRAY_SIZE*A_BITS  same packing as a_vec.
out_valid  out  1  result available; held until accepted.
out_ready  in  1  consumer accepts result.
z  out  Z_BITS  signed dot product.
sat  out  1  saturation occurred in this result; constant 0 when DOT_SAT_EN is undefined.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, step=0, acc=0, z=0, out_valid=0, sat=0, busy=0, in_ready=1 once rst has been released. Reset in RUN or DONE aborts the operation; no output is produced.
- STEPS = ARRAY_SIZE/LANES. The step counter is $clog2(STEPS) bits wide, with a minimum of 1 bit.
- IDLE: in_ready=1. When in_valid&&in_ready: register a_vec/b_vec, clear acc, set step=0, go to RUN. Inputs may change after acceptance.
- RUN: each cycle, acc += sum over l of sext(a[step*LANES+l]*b[step*LANES+l]), then step++.
  - Products are 2*A_BITS signed and are sign-extended to Z_BITS before summing.
  - When step==STEPS-1 the final add happens: z<=acc_next, out_valid<=1, go to DONE.
- DONE: z, sat and out_valid are held stable. When out_valid&&out_ready: out_valid<=0, go to IDLE. in_ready=0 throughout DONE, so there is no overlap.
- Latency: with acceptance at edge k, out_valid rises at edge k+STEPS. Throughput is one result per STEPS+2 cycles, assuming out_ready=1.
- Overflow with DOT_SAT_EN undefined: wraps modulo 2^Z_BITS.
- Handshake rules: in_valid is ignored outside IDLE. out_ready is ignored unless out_valid=1.
- STEPS==1 (LANES==ARRAY_SIZE): RUN lasts exactly one cycle.

Optional Feature:
DOT_SAT_EN
- Defined: each per-cycle accumulation (acc + lane sum) is computed at Z_BITS+$clog2(LANES)+1 bits and clamped to [-2^(Z_BITS-1), 2^(Z_BITS-1)-1].
- Any clamp during an operation sets the sticky sat bit, which is cleared when the next pair is accepted. sat is presented with z.
- Undefined: modular wrap, sat tied to 0, and no extra adder width.

Decomposition:
- Package dot_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} dot_state_t;
  - function dot_steps(ARRAY_SIZE, LANES);
  - saturation-limit helper functions parameterised by width.
- Sub-module dot_lane_sum holds the combinational LANES-way signed multiply and adder tree. It takes the current slice of a/b and returns the sign-extended lane sum. The top level holds the FSM, the counter, the accumulator and saturation.

Test Plan:
- ARRAY_SIZE=4, LANES=1, a={1,2,3,4}, b={5,6,7,8}, accepted at edge k -> out_valid at edge k+4, z=70, sat=0.
- Same vectors with LANES=2 -> z=70 at k+2. Then a={-3,2,-1,4}, b={5,-6,7,8} -> z=-2 (sign handling).
- out_ready held low 3 cycles after out_valid -> z, sat and out_valid stable, in_ready=0 and in_valid ignored. Pair accepted only after DONE->IDLE.
- rst asserted mid-RUN (after 2 steps) -> out_valid=0, z=0 and in_ready=1 once rst is released. A new pair then gives the correct fresh result with no residue.
- Z_BITS=24, A_BITS=12, all elements -2048:
  - without DOT_SAT_EN -> z=0 (2^24 wrapped), sat=0;
  - with DOT_SAT_EN -> z=8388607, sat=1;
  - next pair {1,1,1,1}·{1,1,1,1} -> z=4, sat=0.
- Back-to-back: in_valid held high with three different pairs and out_ready=1 -> three correct results, each STEPS+2 cycles apart.
